hazard_ctrl: RTL and testbench

- Pipeline control unit that drives the fetch-stage controls the PC path consumes: pc_write, pc_mux_control and the redirect target.
- Detects load-use hazards between ID and EX and stalls PC and IF/ID.
- Serves taken branches resolved in EX by redirecting the PC and flushing younger stages.
- Sits between the ID/EX pipeline registers and the PC, PC mux and IF/ID register in the 16-bit RISC pipeline.

---
 rtl/hazard_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_hazard_ctrl.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_ctrl
//
// Fetch-stage control for the 16-bit RISC pipeline. Sits between the ID/EX
// pipeline registers and the PC / PC mux / IF/ID register.
//   * Load-use hazard (load in EX writing a register the ID instruction
//     reads): holds PC and IF/ID and bubbles ID/EX for LOAD_STALL_CYCLES.
//   * Taken branch resolved in EX: redirects the PC to branch_target and
//     flushes IF/ID for FLUSH_CYCLES cycles. A branch always beats a hazard.
//   * stall_count: saturating count of cycles with pc_write=0.
//
// Ports
//   clock, reset          rising-edge clock, asynchronous active-low reset
//   id_rs, id_rt          source registers of the ID instruction
//   id_uses_rt            ID instruction actually reads id_rt
//   ex_rd, ex_mem_read    destination / is-load of the EX instruction
//   branch_taken          EX resolved a taken branch/jump this cycle
//   branch_target         redirect address from EX
//   stat_clear            synchronous clear of stall_count
//   pc_write              PC enable
//   pc_mux_control        0 = PC+2, 1 = pc_redirect
//   pc_redirect           redirect address into the PC mux
//   ifid_write            IF/ID enable
//   ifid_flush            IF/ID loads a NOP
//   idex_bubble           ID/EX loads a NOP
//   stall_count           saturating stall-cycle counter
// ---------------------------------------------------------------------------
module hazard_ctrl #(
    parameter int ADDR_W            = 16,
    parameter int REG_W             = 3,
    parameter int LOAD_STALL_CYCLES = 1,
    parameter int FLUSH_CYCLES      = 1,
    parameter int R0_ZERO           = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [REG_W-1:0]  id_rs,
    input  logic [REG_W-1:0]  id_rt,
    input  logic              id_uses_rt,
    input  logic [REG_W-1:0]  ex_rd,
    input  logic              ex_mem_read,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_target,
    input  logic              stat_clear,
    output logic              pc_write,
    output logic              pc_mux_control,
    output logic [ADDR_W-1:0] pc_redirect,
    output logic              ifid_write,
    output logic              ifid_flush,
    output logic              idex_bubble,
    output logic [15:0]       stall_count
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STALL = 2'd1,
        FLUSH = 2'd2
    } state_t;

    // Counter preloads: the event cycle itself is spent in RUN, so the
    // multi-cycle states cover the remaining N-1 cycles.
    localparam logic [2:0] STALL_INIT = 3'(LOAD_STALL_CYCLES - 1);
    localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_CYCLES - 1);

    state_t      state_reg, state_next;
    logic [2:0]  cnt_reg, cnt_next;
    logic [15:0] stall_count_reg;

    // Per-bit register index comparison against the EX destination.
    logic [REG_W-1:0] rs_eq;
    logic [REG_W-1:0] rt_eq;
    logic             rs_hit;
    logic             rt_hit;
    logic             rd_valid;
    logic             load_use;

    genvar gi;
    generate
        for (gi = 0; gi < REG_W; gi++) begin : g_cmp
            assign rs_eq[gi] = ~(ex_rd[gi] ^ id_rs[gi]);
            assign rt_eq[gi] = ~(ex_rd[gi] ^ id_rt[gi]);
        end
    endgenerate

    assign rs_hit   = &rs_eq;
    assign rt_hit   = (&rt_eq) & id_uses_rt;
    // r0 is hard-wired to zero, so a load "writing" it cannot feed ID.
    assign rd_valid = (R0_ZERO == 0) || (ex_rd != '0);
    assign load_use = ex_mem_read & rd_valid & (rs_hit | rt_hit);

    assign pc_redirect = branch_target;
    assign stall_count = stall_count_reg;

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg <= RUN;
            cnt_reg   <= 3'd0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    // Next state and outputs
    always_comb begin
        pc_write       = 1'b1;
        pc_mux_control = 1'b0;
        ifid_write     = 1'b1;
        ifid_flush     = 1'b0;
        idex_bubble    = 1'b0;
        state_next     = state_reg;
        cnt_next       = cnt_reg;

        if (!reset) begin
            // Reset is asynchronous, so the outputs follow it immediately.
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
            state_next  = RUN;
            cnt_next    = 3'd0;
        end else if (branch_taken) begin
            // Redirect wins in every state; a pending stall is abandoned.
            pc_mux_control = 1'b1;
            ifid_flush     = 1'b1;
            idex_bubble    = 1'b1;
            if (FLUSH_CYCLES > 1) begin
                state_next = FLUSH;
                cnt_next   = FLUSH_INIT;
            end else begin
                state_next = RUN;
                cnt_next   = 3'd0;
            end
        end else begin
            case (state_reg)
                RUN: begin
                    if (load_use) begin
                        pc_write    = 1'b0;
                        ifid_write  = 1'b0;
                        idex_bubble = 1'b1;
                        if (LOAD_STALL_CYCLES > 1) begin
                            state_next = STALL;
                            cnt_next   = STALL_INIT;
                        end
                    end
                end
                STALL: begin
                    // ID is frozen; hazard is re-evaluated only back in RUN.
                    pc_write    = 1'b0;
                    ifid_write  = 1'b0;
                    idex_bubble = 1'b1;
                    cnt_next    = cnt_reg - 3'd1;
                    if (cnt_reg == 3'd1) begin
                        state_next = RUN;
                    end
                end
                FLUSH: begin
                    // ID holds a NOP, so load_use is meaningless here.
                    ifid_flush  = 1'b1;
                    idex_bubble = 1'b1;
                    cnt_next    = cnt_reg - 3'd1;
                    if (cnt_reg == 3'd1) begin
                        state_next = RUN;
                    end
                end
                default: begin
                    state_next = RUN;
                    cnt_next   = 3'd0;
                end
            endcase
        end
    end

    // Stall-cycle statistics; clear has priority over counting.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stall_count_reg <= 16'd0;
        end else if (stat_clear) begin
            stall_count_reg <= 16'd0;
        end else if (!pc_write && (stall_count_reg != 16'hFFFF)) begin
            stall_count_reg <= stall_count_reg + 16'd1;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_hazard_ctrl
//
// Two instances share one stimulus stream:
//   dut_a: LOAD_STALL_CYCLES=1, FLUSH_CYCLES=1 (purely single-cycle events)
//   dut_b: LOAD_STALL_CYCLES=3, FLUSH_CYCLES=2
// Every cycle both are compared against a reference model that tracks
// "stall cycles still owed" and "flush cycles still owed" as plain integers.
// Control outputs are packed as {pc_write, pc_mux_control, ifid_write,
// ifid_flush, idex_bubble}.
// ---------------------------------------------------------------------------
module tb_hazard_ctrl;

    localparam int A_LSC = 1;
    localparam int A_FC  = 1;
    localparam int B_LSC = 3;
    localparam int B_FC  = 2;

    localparam logic [4:0] O_RESET  = 5'b00011;
    localparam logic [4:0] O_IDLE   = 5'b10100;
    localparam logic [4:0] O_STALL  = 5'b00001;
    localparam logic [4:0] O_BRANCH = 5'b11111;
    localparam logic [4:0] O_FLUSH  = 5'b10111;

    logic        clock = 1'b0;
    logic        reset;
    logic [2:0]  id_rs, id_rt, ex_rd;
    logic        id_uses_rt, ex_mem_read, branch_taken, stat_clear;
    logic [15:0] branch_target;

    logic        a_pc_write, a_pc_mux_control, a_ifid_write, a_ifid_flush, a_idex_bubble;
    logic [15:0] a_pc_redirect, a_stall_count;
    logic        b_pc_write, b_pc_mux_control, b_ifid_write, b_ifid_flush, b_idex_bubble;
    logic [15:0] b_pc_redirect, b_stall_count;
    logic [4:0]  a_ctrl, b_ctrl;

    assign a_ctrl = {a_pc_write, a_pc_mux_control, a_ifid_write, a_ifid_flush, a_idex_bubble};
    assign b_ctrl = {b_pc_write, b_pc_mux_control, b_ifid_write, b_ifid_flush, b_idex_bubble};

    always #5 clock = ~clock;

    hazard_ctrl #(
        .ADDR_W(16), .REG_W(3), .LOAD_STALL_CYCLES(A_LSC), .FLUSH_CYCLES(A_FC), .R0_ZERO(1)
    ) dut_a (
        .clock(clock), .reset(reset),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .ex_rd(ex_rd), .ex_mem_read(ex_mem_read),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .stat_clear(stat_clear),
        .pc_write(a_pc_write), .pc_mux_control(a_pc_mux_control),
        .pc_redirect(a_pc_redirect), .ifid_write(a_ifid_write),
        .ifid_flush(a_ifid_flush), .idex_bubble(a_idex_bubble),
        .stall_count(a_stall_count)
    );

    hazard_ctrl #(
        .ADDR_W(16), .REG_W(3), .LOAD_STALL_CYCLES(B_LSC), .FLUSH_CYCLES(B_FC), .R0_ZERO(1)
    ) dut_b (
        .clock(clock), .reset(reset),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .ex_rd(ex_rd), .ex_mem_read(ex_mem_read),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .stat_clear(stat_clear),
        .pc_write(b_pc_write), .pc_mux_control(b_pc_mux_control),
        .pc_redirect(b_pc_redirect), .ifid_write(b_ifid_write),
        .ifid_flush(b_ifid_flush), .idex_bubble(b_idex_bubble),
        .stall_count(b_stall_count)
    );

    int total = 0;
    int bad   = 0;

    // Reference model state
    int m_stall_a = 0, m_flush_a = 0, m_cnt_a = 0;
    int m_stall_b = 0, m_flush_b = 0, m_cnt_b = 0;

    task automatic compare(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            if (bad <= 30)
                $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // A load in EX feeds the ID instruction through a register it reads;
    // r0 never carries a real value.
    function automatic logic model_lu(input logic [2:0] rs, input logic [2:0] rt,
                                      input logic uses, input logic [2:0] rd,
                                      input logic mr);
        return mr && (rd != 0) && ((rd == rs) || (uses && (rd == rt)));
    endfunction

    function automatic void model_step(input int lsc, input int fc, input logic rst,
                                       input logic br, input logic lu,
                                       input int stall_in, input int flush_in,
                                       output logic [4:0] o,
                                       output int stall_out, output int flush_out);
        stall_out = stall_in;
        flush_out = flush_in;
        if (!rst) begin
            o = O_RESET; stall_out = 0; flush_out = 0;
        end else if (br) begin
            o = O_BRANCH; stall_out = 0; flush_out = fc - 1;
        end else if (flush_in > 0) begin
            o = O_FLUSH; flush_out = flush_in - 1;
        end else if (stall_in > 0) begin
            o = O_STALL; stall_out = stall_in - 1;
        end else if (lu) begin
            o = O_STALL; stall_out = lsc - 1;
        end else begin
            o = O_IDLE;
        end
    endfunction

    // One clock cycle: sample at the falling edge, advance the model at the
    // rising edge, return 1 time unit later so the caller can drive inputs.
    task automatic check_cycle(input logic chk_a, input logic [4:0] exp_a,
                               input logic chk_b, input logic [4:0] exp_b,
                               input string tag);
        logic [4:0] ea, eb;
        int nsa, nfa, nsb, nfb;
        logic lu;
        @(negedge clock);
        lu = model_lu(id_rs, id_rt, id_uses_rt, ex_rd, ex_mem_read);
        if (!reset) begin
            m_cnt_a = 0;
            m_cnt_b = 0;
        end
        model_step(A_LSC, A_FC, reset, branch_taken, lu, m_stall_a, m_flush_a, ea, nsa, nfa);
        model_step(B_LSC, B_FC, reset, branch_taken, lu, m_stall_b, m_flush_b, eb, nsb, nfb);
        compare({tag, "_a_ctrl"}, 32'(a_ctrl), 32'(ea));
        compare({tag, "_b_ctrl"}, 32'(b_ctrl), 32'(eb));
        if (chk_a) compare({tag, "_a_hand"}, 32'(a_ctrl), 32'(exp_a));
        if (chk_b) compare({tag, "_b_hand"}, 32'(b_ctrl), 32'(exp_b));
        compare({tag, "_a_redirect"}, 32'(a_pc_redirect), 32'(branch_target));
        compare({tag, "_b_redirect"}, 32'(b_pc_redirect), 32'(branch_target));
        compare({tag, "_a_count"}, 32'(a_stall_count), 32'(m_cnt_a));
        compare({tag, "_b_count"}, 32'(b_stall_count), 32'(m_cnt_b));
        @(posedge clock);
        m_stall_a = nsa; m_flush_a = nfa;
        m_stall_b = nsb; m_flush_b = nfb;
        if (reset) begin
            if (stat_clear) m_cnt_a = 0;
            else if (!ea[4] && m_cnt_a < 65535) m_cnt_a++;
            if (stat_clear) m_cnt_b = 0;
            else if (!eb[4] && m_cnt_b < 65535) m_cnt_b++;
        end
        #1;
    endtask

    task automatic idle_inputs();
        id_rs = 3'd1; id_rt = 3'd2; id_uses_rt = 1'b0; ex_rd = 3'd6;
        ex_mem_read = 1'b0; branch_taken = 1'b0; stat_clear = 1'b0;
    endtask

    typedef struct {
        string       name;
        logic [2:0]  rs, rt, rd;
        logic        uses, mr, br;
        logic [15:0] tgt;
        logic [4:0]  exp;
    } vec_t;

    vec_t vecs[10];

    initial begin
        vecs[0] = '{"lu_rs",      3'd3, 3'd1, 3'd3, 1'b0, 1'b1, 1'b0, 16'h0000, O_STALL};
        vecs[1] = '{"lu_rt",      3'd2, 3'd5, 3'd5, 1'b1, 1'b1, 1'b0, 16'h0002, O_STALL};
        vecs[2] = '{"rt_unused",  3'd2, 3'd5, 3'd5, 1'b0, 1'b1, 1'b0, 16'h0004, O_IDLE};
        vecs[3] = '{"r0_rs",      3'd0, 3'd1, 3'd0, 1'b0, 1'b1, 1'b0, 16'h0006, O_IDLE};
        vecs[4] = '{"no_load",    3'd3, 3'd1, 3'd3, 1'b0, 1'b0, 1'b0, 16'h0008, O_IDLE};
        vecs[5] = '{"diff_reg",   3'd4, 3'd2, 3'd3, 1'b1, 1'b1, 1'b0, 16'h000A, O_IDLE};
        vecs[6] = '{"br_over_lu", 3'd3, 3'd1, 3'd3, 1'b0, 1'b1, 1'b1, 16'h0040, O_BRANCH};
        vecs[7] = '{"br_plain",   3'd1, 3'd2, 3'd6, 1'b0, 1'b0, 1'b1, 16'hBEEE, O_BRANCH};
        vecs[8] = '{"lu_r7_both", 3'd7, 3'd7, 3'd7, 1'b1, 1'b1, 1'b0, 16'h0010, O_STALL};
        vecs[9] = '{"r0_rt",      3'd1, 3'd0, 3'd0, 1'b1, 1'b1, 1'b0, 16'h0012, O_IDLE};

        reset = 1'b0;
        branch_target = 16'h1234;
        idle_inputs();

        // Reset held low for three cycles, then released with no events
        for (int i = 0; i < 3; i++) check_cycle(1'b1, O_RESET, 1'b1, O_RESET, "reset");
        reset = 1'b1;
        check_cycle(1'b1, O_IDLE, 1'b1, O_IDLE, "post_reset");
        compare("post_reset_a_count", 32'(a_stall_count), 32'd0);

        // Load-use on rs for one cycle: A stalls 1 cycle, B stalls 3
        ex_mem_read = 1'b1; ex_rd = 3'd3; id_rs = 3'd3;
        check_cycle(1'b1, O_STALL, 1'b1, O_STALL, "lu1");
        ex_mem_read = 1'b0;
        check_cycle(1'b1, O_IDLE, 1'b1, O_STALL, "lu2");
        check_cycle(1'b1, O_IDLE, 1'b1, O_STALL, "lu3");
        check_cycle(1'b1, O_IDLE, 1'b1, O_IDLE, "lu4");
        compare("lu_a_count", 32'(a_stall_count), 32'd1);
        compare("lu_b_count", 32'(b_stall_count), 32'd3);
        idle_inputs();
        check_cycle(1'b0, O_IDLE, 1'b0, O_IDLE, "gap");

        // Table vectors: dut_a never leaves RUN, so its outputs are a pure
        // function of the vector; dut_b is checked against the model.
        foreach (vecs[i]) begin
            id_rs = vecs[i].rs; id_rt = vecs[i].rt; ex_rd = vecs[i].rd;
            id_uses_rt = vecs[i].uses; ex_mem_read = vecs[i].mr;
            branch_taken = vecs[i].br; branch_target = vecs[i].tgt;
            check_cycle(1'b1, vecs[i].exp, 1'b0, O_IDLE, vecs[i].name);
        end
        idle_inputs();
        for (int i = 0; i < 4; i++) check_cycle(1'b0, O_IDLE, 1'b1, O_IDLE, "drain");

        // Branch with a simultaneous load-use, FLUSH_CYCLES=2 on dut_b
        branch_taken = 1'b1; branch_target = 16'h0040;
        ex_mem_read = 1'b1; ex_rd = 3'd3; id_rs = 3'd3;
        check_cycle(1'b1, O_BRANCH, 1'b1, O_BRANCH, "br1");
        branch_taken = 1'b0;
        check_cycle(1'b1, O_STALL, 1'b1, O_FLUSH, "br2");
        check_cycle(1'b1, O_STALL, 1'b1, O_STALL, "br3");
        ex_mem_read = 1'b0;
        check_cycle(1'b1, O_IDLE, 1'b1, O_STALL, "br4");
        check_cycle(1'b1, O_IDLE, 1'b1, O_STALL, "br5");
        check_cycle(1'b1, O_IDLE, 1'b1, O_IDLE, "br6");

        // Branch arriving mid-stall abandons the remaining stall cycles
        ex_mem_read = 1'b1;
        check_cycle(1'b0, O_IDLE, 1'b1, O_STALL, "bs1");
        ex_mem_read = 1'b0; branch_taken = 1'b1; branch_target = 16'h0100;
        check_cycle(1'b0, O_IDLE, 1'b1, O_BRANCH, "bs2");
        branch_taken = 1'b0;
        check_cycle(1'b0, O_IDLE, 1'b1, O_FLUSH, "bs3");
        check_cycle(1'b0, O_IDLE, 1'b1, O_IDLE, "bs4");

        // Reset asserted in the middle of a stall: no residual count after
        ex_mem_read = 1'b1;
        check_cycle(1'b0, O_IDLE, 1'b1, O_STALL, "rs1");
        ex_mem_read = 1'b0; reset = 1'b0;
        check_cycle(1'b1, O_RESET, 1'b1, O_RESET, "rs2");
        compare("rs_b_count", 32'(b_stall_count), 32'd0);
        reset = 1'b1;
        check_cycle(1'b1, O_IDLE, 1'b1, O_IDLE, "rs3");
        check_cycle(1'b1, O_IDLE, 1'b1, O_IDLE, "rs4");

        // Randomized stimulus against the model
        for (int i = 0; i < 400; i++) begin
            id_rs         = 3'($urandom_range(0, 3));
            id_rt         = 3'($urandom_range(0, 3));
            ex_rd         = 3'($urandom_range(0, 3));
            id_uses_rt    = 1'($urandom_range(0, 1));
            ex_mem_read   = 1'($urandom_range(0, 1));
            branch_taken  = ($urandom_range(0, 7) == 0);
            branch_target = 16'($urandom);
            stat_clear    = ($urandom_range(0, 15) == 0);
            reset         = ($urandom_range(0, 49) != 0);
            check_cycle(1'b0, O_IDLE, 1'b0, O_IDLE, "rand");
        end
        reset = 1'b1;
        idle_inputs();
        check_cycle(1'b0, O_IDLE, 1'b0, O_IDLE, "rand_end");

        // Saturation: continuous load-use keeps pc_write low
        stat_clear = 1'b1;
        check_cycle(1'b0, O_IDLE, 1'b0, O_IDLE, "sat_clr");
        stat_clear = 1'b0;
        ex_mem_read = 1'b1; ex_rd = 3'd4; id_rs = 3'd4;
        for (int i = 0; i < 65540; i++) check_cycle(1'b1, O_STALL, 1'b0, O_IDLE, "sat");
        compare("sat_a_count", 32'(a_stall_count), 32'hFFFF);
        compare("sat_b_count", 32'(b_stall_count), 32'hFFFF);
        stat_clear = 1'b1;
        check_cycle(1'b1, O_STALL, 1'b0, O_IDLE, "sat_clear");
        compare("sat_clear_a_count", 32'(a_stall_count), 32'd0);
        compare("sat_clear_b_count", 32'(b_stall_count), 32'd0);
        stat_clear = 1'b0;
        check_cycle(1'b1, O_STALL, 1'b0, O_IDLE, "sat_after");
        compare("sat_after_a_count", 32'(a_stall_count), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
